// File: rtl/safe_lock_ctrl.sv
// Keypad safe controller: N-symbol code entry, escalating lockout, auto-relock and
// two-pass code programming, driven by debounced clk-synchronous buttons.
module safe_lock_ctrl #(
    parameter int                          BTN_W         = 4,
    parameter int                          CODE_LEN      = 3,
    parameter logic [CODE_LEN*BTN_W-1:0]   DEFAULT_CODE  = 12'hDD7,
    parameter int                          MAX_ERR       = 3,
    parameter longint unsigned             LOCK_CYCLES   = 64'd1000000000,
    parameter int                          MAX_LEVEL     = 3,
    parameter longint unsigned             OPEN_CYCLES   = 64'd500000000,
    parameter longint unsigned             ENTRY_TIMEOUT = 64'd300000000,
    parameter logic [BTN_W-1:0]            PROG_KEY      = 4'b0001
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [BTN_W-1:0]               btn,
    output logic                           unlocked,
    output logic                           lock_led,
    output logic                           prog_mode,
    output logic [$clog2(MAX_ERR+1)-1:0]   err_count,
    output logic [$clog2(MAX_LEVEL+1)-1:0] lock_level,
    output logic                           prog_ok,
    output logic                           prog_fail,
    output logic [2:0]                     fsm_state
);

    localparam int ERR_W  = $clog2(MAX_ERR + 1);
    localparam int LVL_W  = $clog2(MAX_LEVEL + 1);
    localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam longint unsigned LOCK_MAX = LOCK_CYCLES << MAX_LEVEL;
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);
    localparam int OPEN_W = $clog2(OPEN_CYCLES + 1);
    localparam int TO_W   = $clog2(ENTRY_TIMEOUT + 1);
    localparam int W1     = (LOCK_W > OPEN_W) ? LOCK_W : OPEN_W;
    localparam int CNT_W  = (W1 > TO_W) ? W1 : TO_W;

    localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ENTRY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_BASE = CNT_W'(LOCK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CODE_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_LIMIT = ERR_W'(MAX_ERR);
    localparam logic [LVL_W-1:0] LVL_CAP   = LVL_W'(MAX_LEVEL);

    typedef enum logic [2:0] {
        ST_ENTRY     = 3'd0,
        ST_OPEN      = 3'd1,
        ST_PROG_NEW  = 3'd2,
        ST_PROG_CONF = 3'd3,
        ST_LOCKOUT   = 3'd4
    } state_t;

    state_t                      state;
    logic [IDX_W-1:0]            idx;
    logic                        miss;
    logic [CODE_LEN*BTN_W-1:0]   code;
    logic [CODE_LEN*BTN_W-1:0]   shadow;
    logic [BTN_W-1:0]            btn_q;
    logic [CNT_W-1:0]            timer;

    logic                        press;
    logic                        sym_miss;
    logic                        conf_miss;
    logic                        timed_out;
    logic                        last_sym;
    logic [ERR_W-1:0]            err_next;
    logic [CNT_W-1:0]            lock_last;

    assign fsm_state = state;

    always_comb begin
        press     = (btn != '0) && (btn_q == '0);
        sym_miss  = (btn != code[idx*BTN_W +: BTN_W]);
        conf_miss = (btn != shadow[idx*BTN_W +: BTN_W]);
        timed_out = (timer == TO_LAST);
        last_sym  = (idx == IDX_LAST);
        err_next  = err_count + ERR_W'(1);
        lock_last = (LOCK_BASE << lock_level) - CNT_W'(1);
    end

    // One shared cycle timer: idle time in ENTRY/PROG_*, dwell in OPEN, length of LOCKOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ENTRY;
            idx        <= '0;
            miss       <= 1'b0;
            code       <= DEFAULT_CODE;
            shadow     <= '0;
            btn_q      <= '0;
            timer      <= '0;
            unlocked   <= 1'b0;
            lock_led   <= 1'b0;
            prog_mode  <= 1'b0;
            err_count  <= '0;
            lock_level <= '0;
            prog_ok    <= 1'b0;
            prog_fail  <= 1'b0;
        end else begin
            btn_q     <= btn;
            prog_ok   <= 1'b0;
            prog_fail <= 1'b0;
            case (state)
                ST_ENTRY: begin
                    if (press) begin
                        timer <= '0;
                        if (last_sym) begin
                            idx  <= '0;
                            miss <= 1'b0;
                            if (!(miss || sym_miss)) begin
                                state      <= ST_OPEN;
                                unlocked   <= 1'b1;
                                err_count  <= '0;
                                lock_level <= '0;
                            end else if (err_next == ERR_LIMIT) begin
                                state     <= ST_LOCKOUT;
                                lock_led  <= 1'b1;
                                err_count <= '0;
                            end else begin
                                err_count <= err_next;
                            end
                        end else begin
                            idx  <= idx + IDX_W'(1);
                            miss <= miss | sym_miss;
                        end
                    end else if (idx != '0) begin
                        // Stale partial entry is silently dropped; it is not an attempt.
                        if (timed_out) begin
                            idx   <= '0;
                            miss  <= 1'b0;
                            timer <= '0;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                end

                ST_OPEN: begin
                    if (press) begin
                        timer    <= '0;
                        unlocked <= 1'b0;
                        idx      <= '0;
                        miss     <= 1'b0;
                        if (btn == PROG_KEY) begin
                            state     <= ST_PROG_NEW;
                            prog_mode <= 1'b1;
                        end else begin
                            state <= ST_ENTRY;
                        end
                    end else if (timer == OPEN_LAST) begin
                        state    <= ST_ENTRY;
                        unlocked <= 1'b0;
                        timer    <= '0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end

                ST_PROG_NEW: begin
                    if (press) begin
                        timer                       <= '0;
                        shadow[idx*BTN_W +: BTN_W]  <= btn;
                        if (last_sym) begin
                            idx   <= '0;
                            miss  <= 1'b0;
                            state <= ST_PROG_CONF;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (timed_out) begin
                        state     <= ST_ENTRY;
                        prog_mode <= 1'b0;
                        prog_fail <= 1'b1;
                        idx       <= '0;
                        miss      <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end

                ST_PROG_CONF: begin
                    if (press) begin
                        timer <= '0;
                        if (last_sym) begin
                            idx       <= '0;
                            miss      <= 1'b0;
                            state     <= ST_ENTRY;
                            prog_mode <= 1'b0;
                            if (!(miss || conf_miss)) begin
                                code    <= shadow;
                                prog_ok <= 1'b1;
                            end else begin
                                prog_fail <= 1'b1;
                            end
                        end else begin
                            idx  <= idx + IDX_W'(1);
                            miss <= miss | conf_miss;
                        end
                    end else if (timed_out) begin
                        state     <= ST_ENTRY;
                        prog_mode <= 1'b0;
                        prog_fail <= 1'b1;
                        idx       <= '0;
                        miss      <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end

                ST_LOCKOUT: begin
                    // Presses are ignored here; btn_q still tracks so a held button needs release.
                    if (timer == lock_last) begin
                        state    <= ST_ENTRY;
                        lock_led <= 1'b0;
                        timer    <= '0;
                        if (lock_level != LVL_CAP) begin
                            lock_level <= lock_level + LVL_W'(1);
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end

                default: begin
                    state     <= ST_ENTRY;
                    idx       <= '0;
                    miss      <= 1'b0;
                    timer     <= '0;
                    unlocked  <= 1'b0;
                    lock_led  <= 1'b0;
                    prog_mode <= 1'b0;
                end
            endcase
        end
    end

endmodule
